// File: rtl/sm_hex_scan_ctrl.sv
// Seven-segment scan controller: blanked, time-multiplexed digit drive with frame-aligned value updates.
// Outputs registered in step with the scan state; update_req is held off until the next frame boundary, then acked for one cycle.
module sm_hex_scan_ctrl #(
   parameter int DIGITS       = 8,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter bit ANODE_ACTIVE = 1'b0,
   parameter bit SEG_ACTIVE   = 1'b0
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                enable,
   input  logic [4*DIGITS-1:0] number,
   input  logic                update_req,
   output logic                update_ack,
   input  logic                zero_suppress,
   input  logic [DIGITS-1:0]   digit_mask,
   output logic [6:0]          seven_segments,
   output logic [DIGITS-1:0]   anodes,
   output logic                frame_start
);
   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0]     PSC_LAST   = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0]     PSC_DRIVE  = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam state_t            SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
   localparam logic [DIGITS-1:0] ANODE_OFF  = {DIGITS{~ANODE_ACTIVE}};
   localparam logic [6:0]        SEG_OFF    = {7{~SEG_ACTIVE}};

   state_t              state, state_n;
   logic [PW-1:0]       psc, psc_n;
   logic [IW-1:0]       idx, idx_n;
   logic [4*DIGITS-1:0] shadow, shadow_n;
   logic                shadow_zs, zs_n;
   logic                boundary, capture;
   logic [DIGITS-1:0]   lit, onehot;
   logic [3:0]          nib;

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0:    hex_seg = 7'b1000000;
         4'h1:    hex_seg = 7'b1111001;
         4'h2:    hex_seg = 7'b0100100;
         4'h3:    hex_seg = 7'b0110000;
         4'h4:    hex_seg = 7'b0011001;
         4'h5:    hex_seg = 7'b0010010;
         4'h6:    hex_seg = 7'b0000010;
         4'h7:    hex_seg = 7'b1111000;
         4'h8:    hex_seg = 7'b0000000;
         4'h9:    hex_seg = 7'b0010000;
         4'hA:    hex_seg = 7'b0001000;
         4'hB:    hex_seg = 7'b0000011;
         4'hC:    hex_seg = 7'b1000110;
         4'hD:    hex_seg = 7'b0100001;
         4'hE:    hex_seg = 7'b0000110;
         default: hex_seg = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      state_n  = state;
      psc_n    = psc;
      idx_n    = idx;
      boundary = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         psc_n   = '0;
         idx_n   = '0;
      end else if (state == IDLE) begin
         state_n  = SLOT_START;
         psc_n    = '0;
         idx_n    = '0;
         boundary = 1'b1;
      end else if (psc == PSC_LAST) begin
         state_n = SLOT_START;
         psc_n   = '0;
         if (idx == IDX_LAST) begin
            idx_n    = '0;
            boundary = 1'b1;
         end else begin
            idx_n = idx + 1'b1;
         end
      end else begin
         psc_n = psc + 1'b1;
         if (psc_n == PSC_DRIVE) state_n = DRIVE;
      end
   end

   // Outputs are computed from the post-capture shadow so a zero-blank slot still shows the new value.
   assign capture  = boundary & update_req;
   assign shadow_n = capture ? number : shadow;
   assign zs_n     = capture ? zero_suppress : shadow_zs;
   assign nib      = shadow_n[4*idx_n +: 4];
   assign onehot   = DIGITS'(1) << idx_n;

   // Scan from the most significant digit down: run stays high while every nibble so far is zero.
   always_comb begin
      logic run;
      run = 1'b1;
      lit = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run    = run && (shadow_n[4*i +: 4] == 4'h0);
         lit[i] = digit_mask[i] && !(zs_n && (i != 0) && run);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         psc            <= '0;
         idx            <= '0;
         shadow         <= '0;
         shadow_zs      <= 1'b0;
         update_ack     <= 1'b0;
         frame_start    <= 1'b0;
         anodes         <= ANODE_OFF;
         seven_segments <= SEG_OFF;
      end else begin
         state       <= state_n;
         psc         <= psc_n;
         idx         <= idx_n;
         shadow      <= shadow_n;
         shadow_zs   <= zs_n;
         update_ack  <= capture;
         frame_start <= boundary;
         if (state_n == DRIVE && lit[idx_n]) begin
            anodes         <= ANODE_ACTIVE ? onehot : ~onehot;
            seven_segments <= hex_seg(nib) ^ {7{SEG_ACTIVE}};
         end else begin
            anodes         <= ANODE_OFF;
            seven_segments <= SEG_OFF;
         end
      end
   end
endmodule

// File: tb/tb_sm_hex_scan_ctrl.sv
// Directed bench for sm_hex_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles) with a per-cycle expectation queue.
module tb_sm_hex_scan_ctrl;
   localparam int DIGITS = 4;

   logic              clock = 1'b0;
   logic              resetn = 1'b0;
   logic              enable = 1'b0;
   logic              update_req = 1'b0;
   logic              zero_suppress = 1'b0;
   logic [4*DIGITS-1:0] number = '0;
   logic [DIGITS-1:0] digit_mask = '1;
   logic              update_ack, frame_start;
   logic [6:0]        seven_segments;
   logic [DIGITS-1:0] anodes;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [3:0] an;
      logic [6:0] seg;
      logic       fs;
      logic       ack;
   } exp_t;

   exp_t sb[$];

   sm_hex_scan_ctrl #(
      .DIGITS(DIGITS), .SCAN_DIV(8), .BLANK_CYCLES(2), .ANODE_ACTIVE(1'b0), .SEG_ACTIVE(1'b0)
   ) dut (
      .clock(clock), .resetn(resetn), .enable(enable), .number(number),
      .update_req(update_req), .update_ack(update_ack), .zero_suppress(zero_suppress),
      .digit_mask(digit_mask), .seven_segments(seven_segments), .anodes(anodes),
      .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] seg_ref(input logic [3:0] v);
      case (v)
         4'h0: seg_ref = 7'h40;  4'h1: seg_ref = 7'h79;  4'h2: seg_ref = 7'h24;  4'h3: seg_ref = 7'h30;
         4'h4: seg_ref = 7'h19;  4'h5: seg_ref = 7'h12;  4'h6: seg_ref = 7'h02;  4'h7: seg_ref = 7'h78;
         4'h8: seg_ref = 7'h00;  4'h9: seg_ref = 7'h10;  4'hA: seg_ref = 7'h08;  4'hB: seg_ref = 7'h03;
         4'hC: seg_ref = 7'h46;  4'hD: seg_ref = 7'h21;  4'hE: seg_ref = 7'h06;  default: seg_ref = 7'h0E;
      endcase
   endfunction

   task automatic push(input string tag, input logic [3:0] an, input logic [6:0] seg,
                       input logic fs, input logic ack);
      exp_t e;
      e.tag = tag; e.an = an; e.seg = seg; e.fs = fs; e.ack = ack;
      sb.push_back(e);
   endtask

   task automatic push_off(input string tag, input int n);
      for (int i = 0; i < n; i++) push(tag, 4'hF, 7'h7F, 1'b0, 1'b0);
   endtask

   // One frame = 4 slots of 8 cycles; a digit lights on slot cycles 2..7 unless masked or leading-zero blanked.
   task automatic expect_frame(input string tag, input logic [15:0] val, input logic zs,
                               input logic [3:0] mask, input logic ack, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         int         d, p;
         logic       on;
         logic [3:0] an;
         logic [6:0] seg;
         d  = c / 8;
         p  = c % 8;
         on = (p >= 2) && mask[d] && !(zs && d > 0 && (val >> (4*d)) == 16'h0);
         an  = on ? ~(4'b0001 << d) : 4'hF;
         seg = on ? seg_ref(val[4*d +: 4]) : 7'h7F;
         push($sformatf("%s d%0d p%0d", tag, d, p), an, seg, (c == 0), ack && (c == 0));
      end
   endtask

   task automatic check_now();
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty: got %0d entries, expected at least 1", sb.size());
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         assert (anodes === e.an) else begin
            errors++; $error("FAIL %s anodes: got %b expected %b", e.tag, anodes, e.an);
         end
         checks++;
         assert (seven_segments === e.seg) else begin
            errors++; $error("FAIL %s seg: got %b expected %b", e.tag, seven_segments, e.seg);
         end
         checks++;
         assert (frame_start === e.fs) else begin
            errors++; $error("FAIL %s frame_start: got %b expected %b", e.tag, frame_start, e.fs);
         end
         checks++;
         assert (update_ack === e.ack) else begin
            errors++; $error("FAIL %s update_ack: got %b expected %b", e.tag, update_ack, e.ack);
         end
      end
   endtask

   // Sample on the falling edge; the requester drops update_req as soon as it sees the ack.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         check_now();
         if (update_ack === 1'b1) update_req = 1'b0;
      end
   endtask

   initial begin
      push_off("reset", 1);
      step(1);

      resetn = 1'b1; enable = 1'b1; number = 16'h1234; update_req = 1'b1;
      expect_frame("load1234", 16'h1234, 1'b0, 4'hF, 1'b1, 32);
      step(32);

      expect_frame("hold1234", 16'h1234, 1'b0, 4'hF, 1'b0, 32);
      step(18);
      number = 16'hABCD; update_req = 1'b1;
      step(14);
      expect_frame("loadABCD", 16'hABCD, 1'b0, 4'hF, 1'b1, 32);
      step(32);

      zero_suppress = 1'b1; number = 16'h0005; update_req = 1'b1;
      expect_frame("zs0005", 16'h0005, 1'b1, 4'hF, 1'b1, 32);
      step(32);
      number = 16'h0000; update_req = 1'b1;
      expect_frame("zs0000", 16'h0000, 1'b1, 4'hF, 1'b1, 32);
      step(32);

      zero_suppress = 1'b0; number = 16'h1234; update_req = 1'b1; digit_mask = 4'b1011;
      expect_frame("mask1011", 16'h1234, 1'b0, 4'b1011, 1'b1, 32);
      step(32);
      digit_mask = 4'hF;
      expect_frame("unmask", 16'h1234, 1'b0, 4'hF, 1'b0, 12);
      step(12);

      enable = 1'b0; number = 16'h5678; update_req = 1'b1;
      push_off("disabled", 3);
      step(3);
      enable = 1'b1;
      expect_frame("reenable", 16'h5678, 1'b0, 4'hF, 1'b1, 11);
      step(11);

      #2 resetn = 1'b0;
      #1 push_off("async_reset", 1);
      check_now();
      enable = 1'b0; update_req = 1'b0;
      push_off("in_reset", 1);
      step(1);
      resetn = 1'b1;
      push_off("idle", 1);
      step(1);
      enable = 1'b1;
      expect_frame("after_reset", 16'h0000, 1'b0, 4'hF, 1'b0, 32);
      step(32);

      checks++;
      assert (sb.size() == 0) else begin
         errors++; $error("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
